ysyx_220066_ex_stage: RTL and testbench

- Execute stage of the 5-stage RV64 in-order core (IF → ID → EX → M → WB).
- Registers the ID-stage bundle each cycle, then computes the ALU result, branch/jump resolution and next PC combinationally from the registered values.
- Passes memory, register-write and CSR control on to the M stage and the CSR unit.

---
 rtl/ysyx_220066_ex_stage_pkg.sv | 62 ++++++
 rtl/ysyx_220066_ex_stage_if.sv | 43 ++++
 rtl/ysyx_220066_ex_stage_alu.sv | 43 ++++
 rtl/ysyx_220066_ex_stage.sv | 129 ++++++++++++
 tb/tb_ysyx_220066_ex_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_220066_ex_stage_pkg.sv
// Shared constants and the registered-bundle type for the RV64 execute stage.
// ALU op encodings use ALUctr[3:0]; ALUctr[4] selects 32-bit word mode.
package ysyx_220066_ex_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    // Branch[3]=1 marks a conditional branch whose low bits are funct3.
    localparam logic [3:0] BR_NONE = 4'b0000;
    localparam logic [3:0] BR_JAL  = 4'b0001;
    localparam logic [3:0] BR_JALR = 4'b0010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ASRC_REG  = 2'b00;
    localparam logic [1:0] ASRC_PC   = 2'b01;
    localparam logic [1:0] ASRC_ZERO = 2'b10;
    localparam logic [1:0] BSRC_REG  = 2'b00;
    localparam logic [1:0] BSRC_IMM  = 2'b01;
    localparam logic [1:0] BSRC_FOUR = 2'b10;

    typedef struct packed {
        logic            valid;
        logic            error;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] csr_data;
        logic [11:0]     csr_addr;
        logic            csr;
        logic            ecall;
        logic            mret;
        logic            done;
        logic [1:0]      asrc;
        logic [1:0]      bsrc;
        logic [4:0]      alu_ctr;
        logic [3:0]      branch;
        logic [2:0]      mem_op;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
    } ex_reg_t;

endpackage

// File: rtl/ysyx_220066_ex_stage_if.sv
// ID->EX bundle and EX->M/CSR outputs of the execute stage.
// valid_in qualifies the ID bundle; block=1 stalls (EX holds its register and
// ignores the bundle); valid = valid_native & ~raise_intr marks a committing EX op.
interface ysyx_220066_ex_stage_if;
    import ysyx_220066_ex_pkg::*;

    logic            block, valid_in, error_in, raise_intr;
    logic [4:0]      rd_in, rs1_in;
    logic [XLEN-1:0] src1_in, src2_in, imm_in, pc_in, csr_data_in;
    logic [11:0]     csr_addr_in;
    logic            csr_in, ecall_in, mret_in, done_in;
    logic [1:0]      ALUAsrc_in, ALUBsrc_in;
    logic [4:0]      ALUctr_in;
    logic [3:0]      Branch_in;
    logic [2:0]      MemOp_in;
    logic            MemRd_in, MemWr_in, RegWr_in;

    logic            valid_native, valid, error;
    logic [XLEN-1:0] pc, src1, src2, csr_data, result, nxtpc;
    logic [4:0]      rs1, rd;
    logic [11:0]     csr_addr;
    logic            RegWr, MemRd, MemWr, csr, ecall, mret, done, is_jmp;
    logic [2:0]      MemOp;

    modport master (
        output block, valid_in, error_in, raise_intr, rd_in, rs1_in, src1_in, src2_in,
               imm_in, pc_in, csr_data_in, csr_addr_in, csr_in, ecall_in, mret_in, done_in,
               ALUAsrc_in, ALUBsrc_in, ALUctr_in, Branch_in, MemOp_in, MemRd_in, MemWr_in,
               RegWr_in,
        input  valid_native, valid, error, pc, src1, src2, csr_data, result, nxtpc, rs1, rd,
               csr_addr, RegWr, MemRd, MemWr, csr, ecall, mret, done, is_jmp, MemOp
    );

    modport slave (
        input  block, valid_in, error_in, raise_intr, rd_in, rs1_in, src1_in, src2_in,
               imm_in, pc_in, csr_data_in, csr_addr_in, csr_in, ecall_in, mret_in, done_in,
               ALUAsrc_in, ALUBsrc_in, ALUctr_in, Branch_in, MemOp_in, MemRd_in, MemWr_in,
               RegWr_in,
        output valid_native, valid, error, pc, src1, src2, csr_data, result, nxtpc, rs1, rd,
               csr_addr, RegWr, MemRd, MemWr, csr, ecall, mret, done, is_jmp, MemOp
    );

endinterface

// File: rtl/ysyx_220066_ex_stage_alu.sv
// Combinational RV64 ALU. ctl[4] selects word mode: operate on the low 32 bits
// and sign-extend the 32-bit result.
module ysyx_220066_ex_alu
    import ysyx_220066_ex_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      ctl,
    output logic [XLEN-1:0] result
);

    logic            word;
    logic [5:0]      shamt;
    logic [XLEN-1:0] a_op, b_op, a_srl, full;
    logic [31:0]     low;

    always_comb begin
        word  = ctl[4];
        shamt = word ? {1'b0, b[4:0]} : b[5:0];
        // Sign-extended word operands keep signed and unsigned ordering intact.
        a_op  = word ? {{32{a[31]}}, a[31:0]} : a;
        b_op  = word ? {{32{b[31]}}, b[31:0]} : b;
        a_srl = word ? {32'b0, a[31:0]} : a;
        full  = '0;
        case (ctl[3:0])
            ALU_ADD:   full = a_op + b_op;
            ALU_SUB:   full = a_op - b_op;
            ALU_SLL:   full = a_op << shamt;
            ALU_SLT:   full = {{(XLEN-1){1'b0}}, $signed(a_op) < $signed(b_op)};
            ALU_SLTU:  full = {{(XLEN-1){1'b0}}, a_op < b_op};
            ALU_XOR:   full = a_op ^ b_op;
            ALU_SRL:   full = a_srl >> shamt;
            ALU_SRA:   full = $signed(a_op) >>> shamt;
            ALU_OR:    full = a_op | b_op;
            ALU_AND:   full = a_op & b_op;
            ALU_PASSB: full = b_op;
            default:   full = '0;
        endcase
        low    = full[31:0];
        result = word ? {{32{low[31]}}, low} : full;
    end

endmodule

// File: rtl/ysyx_220066_ex_stage.sv
// Execute stage: ID->EX pipeline register, ALU, branch resolution and next PC.
// Optional EX_MISALIGN_CHK_EN: a misaligned redirect target raises error instead of jumping.
module ysyx_220066_ex_stage #(
    parameter int          XLEN            = ysyx_220066_ex_pkg::XLEN,
    parameter logic [63:0] RESET_PC_UNUSED = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_220066_ex_stage_if.slave  ex
);
    import ysyx_220066_ex_pkg::*;

    ex_reg_t         d, r;
    logic [XLEN-1:0] alu_a, alu_b, alu_out, nxtpc, br_tgt, jalr_sum;
    logic            cond_taken, is_jal, is_jalr, br_taken, redirect, trap_free;
    logic            unused_pc_param;

    assign unused_pc_param = (RESET_PC_UNUSED != 64'h0);

    always_comb begin
        d          = '0;
        d.valid    = ex.valid_in;
        d.error    = ex.error_in;
        d.rd       = ex.rd_in;
        d.rs1      = ex.rs1_in;
        d.src1     = ex.src1_in;
        d.src2     = ex.src2_in;
        d.imm      = ex.imm_in;
        d.pc       = ex.pc_in;
        d.csr_data = ex.csr_data_in;
        d.csr_addr = ex.csr_addr_in;
        d.csr      = ex.csr_in;
        d.ecall    = ex.ecall_in;
        d.mret     = ex.mret_in;
        d.done     = ex.done_in;
        d.asrc     = ex.ALUAsrc_in;
        d.bsrc     = ex.ALUBsrc_in;
        d.alu_ctr  = ex.ALUctr_in;
        d.branch   = ex.Branch_in;
        d.mem_op   = ex.MemOp_in;
        d.mem_rd   = ex.MemRd_in;
        d.mem_wr   = ex.MemWr_in;
        d.reg_wr   = ex.RegWr_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r <= '0;
        else if (!ex.block) r <= d;
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (r.asrc)
            ASRC_REG: alu_a = r.src1;
            ASRC_PC:  alu_a = r.pc;
            default:  alu_a = '0;
        endcase
        case (r.bsrc)
            BSRC_REG:  alu_b = r.src2;
            BSRC_IMM:  alu_b = r.imm;
            BSRC_FOUR: alu_b = XLEN'(4);
            default:   alu_b = '0;
        endcase
    end

    ysyx_220066_ex_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctl    (r.alu_ctr),
        .result (alu_out)
    );

    always_comb begin
        cond_taken = 1'b0;
        case (r.branch[2:0])
            F3_BEQ:  cond_taken = (r.src1 == r.src2);
            F3_BNE:  cond_taken = (r.src1 != r.src2);
            F3_BLT:  cond_taken = ($signed(r.src1) <  $signed(r.src2));
            F3_BGE:  cond_taken = ($signed(r.src1) >= $signed(r.src2));
            F3_BLTU: cond_taken = (r.src1 <  r.src2);
            F3_BGEU: cond_taken = (r.src1 >= r.src2);
            default: cond_taken = 1'b0;
        endcase
        is_jal   = (r.branch == BR_JAL);
        is_jalr  = (r.branch == BR_JALR);
        br_taken = r.branch[3] & cond_taken;
        redirect = is_jal | is_jalr | br_taken;
        br_tgt   = r.pc + r.imm;
        jalr_sum = r.src1 + r.imm;
        if (is_jalr)                 nxtpc = {jalr_sum[XLEN-1:1], 1'b0};
        else if (is_jal | br_taken)  nxtpc = br_tgt;
        else                         nxtpc = r.pc + XLEN'(4);
    end

    // ecall/mret/done are redirected by the CSR unit, never by this stage.
    assign trap_free = ~(r.ecall | r.mret | r.done);

    assign ex.valid_native = r.valid;
    assign ex.valid        = r.valid & ~ex.raise_intr;
    assign ex.pc           = r.pc;
    assign ex.src1         = r.src1;
    assign ex.src2         = r.src2;
    assign ex.csr_data     = r.csr_data;
    assign ex.rs1          = r.rs1;
    assign ex.rd           = r.rd;
    assign ex.csr_addr     = r.csr_addr;
    assign ex.RegWr        = r.reg_wr;
    assign ex.MemRd        = r.mem_rd;
    assign ex.MemWr        = r.mem_wr;
    assign ex.csr          = r.csr;
    assign ex.ecall        = r.ecall;
    assign ex.mret         = r.mret;
    assign ex.done         = r.done;
    assign ex.MemOp        = r.mem_op;
    assign ex.result       = r.csr ? r.csr_data : alu_out;
    assign ex.nxtpc        = nxtpc;

`ifdef EX_MISALIGN_CHK_EN
    logic misalign;
    assign misalign  = redirect & trap_free & (nxtpc[1:0] != 2'b00);
    assign ex.is_jmp = ex.valid & redirect & trap_free & ~misalign;
    assign ex.error  = r.error | (r.valid & misalign);
`else
    assign ex.is_jmp = ex.valid & redirect & trap_free;
    assign ex.error  = r.error;
`endif

endmodule

// File: tb/tb_ysyx_220066_ex_stage.sv
// Self-checking bench for ysyx_220066_ex_stage: directed scenarios plus a random
// back-to-back stream checked against an independent reference model.
module tb_ysyx_220066_ex_stage;
    import ysyx_220066_ex_pkg::*;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] nxtpc;
        logic        is_jmp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    ysyx_220066_ex_stage_if ex_if ();

    ysyx_220066_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input ex_reg_t s);
        ex_if.valid_in    = s.valid;
        ex_if.error_in    = s.error;
        ex_if.rd_in       = s.rd;
        ex_if.rs1_in      = s.rs1;
        ex_if.src1_in     = s.src1;
        ex_if.src2_in     = s.src2;
        ex_if.imm_in      = s.imm;
        ex_if.pc_in       = s.pc;
        ex_if.csr_data_in = s.csr_data;
        ex_if.csr_addr_in = s.csr_addr;
        ex_if.csr_in      = s.csr;
        ex_if.ecall_in    = s.ecall;
        ex_if.mret_in     = s.mret;
        ex_if.done_in     = s.done;
        ex_if.ALUAsrc_in  = s.asrc;
        ex_if.ALUBsrc_in  = s.bsrc;
        ex_if.ALUctr_in   = s.alu_ctr;
        ex_if.Branch_in   = s.branch;
        ex_if.MemOp_in    = s.mem_op;
        ex_if.MemRd_in    = s.mem_rd;
        ex_if.MemWr_in    = s.mem_wr;
        ex_if.RegWr_in    = s.reg_wr;
    endtask

    function automatic exp_t mk_exp(input logic [63:0] r, input logic [63:0] n, input logic j);
        exp_t e;
        e.result = r;
        e.nxtpc  = n;
        e.is_jmp = j;
        return e;
    endfunction

    // Reference model written from the instruction semantics, not the RTL structure.
    function automatic exp_t model(input ex_reg_t s);
        logic [63:0] a, b, r, tgt;
        logic [31:0] x, y, w;
        logic        tk;
        exp_t        m;
        case (s.asrc)
            2'b00:   a = s.src1;
            2'b01:   a = s.pc;
            default: a = 64'd0;
        endcase
        case (s.bsrc)
            2'b00:   b = s.src2;
            2'b01:   b = s.imm;
            2'b10:   b = 64'd4;
            default: b = 64'd0;
        endcase
        x = a[31:0];
        y = b[31:0];
        w = 32'd0;
        r = 64'd0;
        if (s.alu_ctr[4]) begin
            case (s.alu_ctr[3:0])
                4'b0000: w = x + y;
                4'b1000: w = x - y;
                4'b0001: w = x << y[4:0];
                4'b0010: w = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                4'b0011: w = (x < y) ? 32'd1 : 32'd0;
                4'b0100: w = x ^ y;
                4'b0101: w = x >> y[4:0];
                4'b1101: w = $signed(x) >>> y[4:0];
                4'b0110: w = x | y;
                4'b0111: w = x & y;
                4'b1111: w = y;
                default: w = 32'd0;
            endcase
            r = {{32{w[31]}}, w};
        end else begin
            case (s.alu_ctr[3:0])
                4'b0000: r = a + b;
                4'b1000: r = a - b;
                4'b0001: r = a << b[5:0];
                4'b0010: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                4'b0011: r = (a < b) ? 64'd1 : 64'd0;
                4'b0100: r = a ^ b;
                4'b0101: r = a >> b[5:0];
                4'b1101: r = $signed(a) >>> b[5:0];
                4'b0110: r = a | b;
                4'b0111: r = a & b;
                4'b1111: r = b;
                default: r = 64'd0;
            endcase
        end
        tk  = 1'b0;
        tgt = s.pc + 64'd4;
        if (s.branch == 4'b0001) begin
            tk  = 1'b1;
            tgt = s.pc + s.imm;
        end else if (s.branch == 4'b0010) begin
            tk  = 1'b1;
            tgt = (s.src1 + s.imm) & ~64'd1;
        end else if (s.branch[3]) begin
            case (s.branch[2:0])
                3'b000:  tk = (s.src1 == s.src2);
                3'b001:  tk = (s.src1 != s.src2);
                3'b100:  tk = ($signed(s.src1) < $signed(s.src2));
                3'b101:  tk = ($signed(s.src1) >= $signed(s.src2));
                3'b110:  tk = (s.src1 < s.src2);
                3'b111:  tk = (s.src1 >= s.src2);
                default: tk = 1'b0;
            endcase
            if (tk) tgt = s.pc + s.imm;
        end
        m.result = s.csr ? s.csr_data : r;
        m.nxtpc  = tgt;
        m.is_jmp = s.valid & tk & ~(s.ecall | s.mret | s.done);
        return m;
    endfunction

    task automatic test_reset();
        ex_reg_t s;
        exp_t    e;
        s = '0;
        s.valid = 1'b1; s.error = 1'b1; s.pc = 64'h1230; s.branch = 4'b0001; s.imm = 64'h40;
        rst = 1'b0;
        ex_if.block = 1'b0;
        ex_if.raise_intr = 1'b0;
        drive(s);
        exp_q.push_back(mk_exp(64'd0, 64'd4, 1'b0));
        step();
        step();
        e = exp_q.pop_front();
        n_cmp++; if (ex_if.valid_native !== 1'b0) begin n_err++; $display("FAIL reset_valid_native: got %b want 0", ex_if.valid_native); end
        n_cmp++; if (ex_if.error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", ex_if.error); end
        n_cmp++; if (ex_if.is_jmp !== e.is_jmp) begin n_err++; $display("FAIL reset_is_jmp: got %b want %b", ex_if.is_jmp, e.is_jmp); end
        n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL reset_result: got %h want %h", ex_if.result, e.result); end
        n_cmp++; if (ex_if.nxtpc !== e.nxtpc) begin n_err++; $display("FAIL reset_nxtpc: got %h want %h", ex_if.nxtpc, e.nxtpc); end
        rst = 1'b1;
        drive('0);
    endtask

    task automatic test_addw();
        ex_reg_t s;
        exp_t    e;
        s = '0;
        s.valid = 1'b1; s.alu_ctr = 5'b10000; s.src1 = 64'h7FFF_FFFF; s.imm = 64'd1;
        s.bsrc = BSRC_IMM; s.reg_wr = 1'b1; s.pc = 64'h8000_0000; s.rd = 5'd3;
        drive(s);
        exp_q.push_back(mk_exp(64'hFFFF_FFFF_8000_0000, 64'h8000_0004, 1'b0));
        step();
        e = exp_q.pop_front();
        n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL addw_result: got %h want %h", ex_if.result, e.result); end
        n_cmp++; if (ex_if.nxtpc !== e.nxtpc) begin n_err++; $display("FAIL addw_nxtpc: got %h want %h", ex_if.nxtpc, e.nxtpc); end
        n_cmp++; if (ex_if.is_jmp !== e.is_jmp) begin n_err++; $display("FAIL addw_is_jmp: got %b want %b", ex_if.is_jmp, e.is_jmp); end
        n_cmp++; if ({ex_if.valid, ex_if.RegWr, ex_if.rd} !== {1'b1, 1'b1, 5'd3}) begin
            n_err++; $display("FAIL addw_ctrl: got valid=%b RegWr=%b rd=%0d want 1 1 3", ex_if.valid, ex_if.RegWr, ex_if.rd);
        end
    endtask

    task automatic test_branch();
        ex_reg_t     s;
        exp_t        e;
        logic [3:0]  brs[7];
        logic [63:0] av[7], bv[7];
        logic        tk[7];
        brs = '{4'b1000, 4'b1000, 4'b1001, 4'b1100, 4'b1110, 4'b1101, 4'b1111};
        av  = '{64'd5, 64'd5, 64'd5, '1, '1, 64'd3, 64'd1};
        bv  = '{64'd5, 64'd6, 64'd5, 64'd1, 64'd1, 64'd3, '1};
        tk  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            s = '0;
            s.valid = 1'b1; s.branch = brs[i]; s.src1 = av[i]; s.src2 = bv[i];
            s.pc = 64'h8000_0000; s.imm = 64'h10;
            drive(s);
            exp_q.push_back(mk_exp(av[i] + bv[i], tk[i] ? 64'h8000_0010 : 64'h8000_0004, tk[i]));
            step();
            e = exp_q.pop_front();
            n_cmp++; if (ex_if.is_jmp !== e.is_jmp) begin n_err++; $display("FAIL branch%0d_is_jmp: got %b want %b", i, ex_if.is_jmp, e.is_jmp); end
            n_cmp++; if (ex_if.nxtpc !== e.nxtpc) begin n_err++; $display("FAIL branch%0d_nxtpc: got %h want %h", i, ex_if.nxtpc, e.nxtpc); end
            n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL branch%0d_result: got %h want %h", i, ex_if.result, e.result); end
        end
    endtask

    task automatic test_jump();
        ex_reg_t s;
        exp_t    e;
        for (int i = 0; i < 4; i++) begin
            s = '0;
            s.valid = 1'b1; s.pc = 64'h8000_0000; s.asrc = ASRC_PC; s.bsrc = BSRC_FOUR; s.imm = 64'h40;
            case (i)
                0: begin s.branch = 4'b0010; s.src1 = 64'h8000_0101; s.imm = 64'd2;
                         exp_q.push_back(mk_exp(64'h8000_0004, 64'h8000_0102, 1'b1)); end
                1: begin s.branch = 4'b0001; s.imm = 64'hFFFF_FFFF_FFFF_FFF8;
                         exp_q.push_back(mk_exp(64'h8000_0004, 64'h7FFF_FFF8, 1'b1)); end
                2: begin s.branch = 4'b0011;
                         exp_q.push_back(mk_exp(64'h8000_0004, 64'h8000_0004, 1'b0)); end
                default: begin s.branch = 4'b0001; s.valid = 1'b0;
                         exp_q.push_back(mk_exp(64'h8000_0004, 64'h8000_0040, 1'b0)); end
            endcase
            drive(s);
            step();
            e = exp_q.pop_front();
            n_cmp++; if (ex_if.nxtpc !== e.nxtpc) begin n_err++; $display("FAIL jump%0d_nxtpc: got %h want %h", i, ex_if.nxtpc, e.nxtpc); end
            n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL jump%0d_result: got %h want %h", i, ex_if.result, e.result); end
            n_cmp++; if (ex_if.is_jmp !== e.is_jmp) begin n_err++; $display("FAIL jump%0d_is_jmp: got %b want %b", i, ex_if.is_jmp, e.is_jmp); end
        end
    endtask

    task automatic test_stall();
        ex_reg_t s, h;
        exp_t    e;
        s = '0;
        s.valid = 1'b1; s.src1 = 64'h1111; s.imm = 64'h22; s.bsrc = BSRC_IMM;
        s.pc = 64'h8000_0200; s.rd = 5'd4;
        drive(s);
        exp_q.push_back(mk_exp(64'h1133, 64'h8000_0204, 1'b0));
        step();
        e = exp_q.pop_front();
        n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL stall_pre_result: got %h want %h", ex_if.result, e.result); end
        ex_if.block = 1'b1;
        h = '0;
        for (int i = 0; i < 3; i++) begin
            h = '0;
            h.valid = 1'b1; h.src1 = {$urandom, $urandom}; h.imm = {32'd0, $urandom} & ~64'd3;
            h.bsrc = BSRC_IMM; h.pc = {$urandom, $urandom} & ~64'd3; h.rd = 5'($urandom_range(5, 31));
            h.branch = 4'b0001;
            drive(h);
            exp_q.push_back(mk_exp(64'h1133, 64'h8000_0204, 1'b0));
            step();
            e = exp_q.pop_front();
            n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL stall%0d_result: got %h want %h", i, ex_if.result, e.result); end
            n_cmp++; if (ex_if.nxtpc !== e.nxtpc) begin n_err++; $display("FAIL stall%0d_nxtpc: got %h want %h", i, ex_if.nxtpc, e.nxtpc); end
            n_cmp++; if (ex_if.is_jmp !== e.is_jmp) begin n_err++; $display("FAIL stall%0d_is_jmp: got %b want %b", i, ex_if.is_jmp, e.is_jmp); end
            n_cmp++; if ({ex_if.pc, ex_if.rd} !== {64'h8000_0200, 5'd4}) begin
                n_err++; $display("FAIL stall%0d_hold: got pc=%h rd=%0d want 80000200 4", i, ex_if.pc, ex_if.rd);
            end
        end
        ex_if.block = 1'b0;
        exp_q.push_back(mk_exp(h.src1 + h.imm, h.pc + h.imm, 1'b1));
        step();
        e = exp_q.pop_front();
        n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL stall_release_result: got %h want %h", ex_if.result, e.result); end
        n_cmp++; if (ex_if.nxtpc !== e.nxtpc) begin n_err++; $display("FAIL stall_release_nxtpc: got %h want %h", ex_if.nxtpc, e.nxtpc); end
        n_cmp++; if (ex_if.is_jmp !== e.is_jmp) begin n_err++; $display("FAIL stall_release_is_jmp: got %b want %b", ex_if.is_jmp, e.is_jmp); end
    endtask

    task automatic test_ecall();
        ex_reg_t s;
        s = '0;
        s.valid = 1'b1; s.ecall = 1'b1; s.pc = 64'h8000_0100;
        drive(s);
        step();
        ex_if.raise_intr = 1'b1;
        #1;
        n_cmp++; if ({ex_if.valid, ex_if.valid_native, ex_if.ecall, ex_if.is_jmp} !== 4'b0110) begin
            n_err++; $display("FAIL ecall_intr: got valid=%b native=%b ecall=%b jmp=%b want 0 1 1 0",
                              ex_if.valid, ex_if.valid_native, ex_if.ecall, ex_if.is_jmp);
        end
        ex_if.raise_intr = 1'b0;
        #1;
        n_cmp++; if (ex_if.valid !== 1'b1) begin n_err++; $display("FAIL ecall_nointr_valid: got %b want 1", ex_if.valid); end
        s = '0;
        s.valid = 1'b1; s.mret = 1'b1; s.branch = 4'b0001; s.imm = 64'h40; s.pc = 64'h8000_0100;
        drive(s);
        step();
        n_cmp++; if ({ex_if.valid, ex_if.mret, ex_if.is_jmp} !== 3'b110) begin
            n_err++; $display("FAIL mret_no_jmp: got valid=%b mret=%b jmp=%b want 1 1 0", ex_if.valid, ex_if.mret, ex_if.is_jmp);
        end
    endtask

    task automatic test_csr();
        ex_reg_t s;
        exp_t    e;
        s = '0;
        s.valid = 1'b1; s.csr = 1'b1; s.csr_data = 64'h1800; s.csr_addr = 12'h300;
        s.mem_op = 3'b010; s.rs1 = 5'd9; s.src1 = 64'hDEAD_BEEF; s.reg_wr = 1'b1; s.pc = 64'h8000_0300;
        drive(s);
        exp_q.push_back(mk_exp(64'h1800, 64'h8000_0304, 1'b0));
        step();
        e = exp_q.pop_front();
        n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL csr_result: got %h want %h", ex_if.result, e.result); end
        n_cmp++; if ({ex_if.MemOp, ex_if.rs1, ex_if.src1, ex_if.csr_addr, ex_if.csr} !== {3'b010, 5'd9, 64'hDEAD_BEEF, 12'h300, 1'b1}) begin
            n_err++; $display("FAIL csr_fwd: got MemOp=%b rs1=%0d src1=%h addr=%h csr=%b want 010 9 deadbeef 300 1",
                              ex_if.MemOp, ex_if.rs1, ex_if.src1, ex_if.csr_addr, ex_if.csr);
        end
    endtask

    task automatic test_back_to_back();
        ex_reg_t    s;
        exp_t       e;
        logic [3:0] ops[11];
        logic [3:0] brs[10];
        ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111};
        brs = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000,
                4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        for (int i = 0; i < 80; i++) begin
            s = '0;
            s.valid    = ($urandom_range(0, 3) != 0);
            s.src1     = {$urandom, $urandom};
            s.src2     = ($urandom_range(0, 3) == 0) ? s.src1 : {$urandom, $urandom};
            s.imm      = {$urandom, $urandom} & ~64'd3;
            s.pc       = {$urandom, $urandom} & ~64'd3;
            s.csr_data = {$urandom, $urandom};
            s.csr      = ($urandom_range(0, 7) == 0);
            s.done     = ($urandom_range(0, 7) == 0);
            s.asrc     = 2'($urandom_range(0, 3));
            s.bsrc     = 2'($urandom_range(0, 3));
            s.alu_ctr  = {1'($urandom_range(0, 1)), ops[$urandom_range(0, 10)]};
            s.branch   = brs[$urandom_range(0, 9)];
            if (s.branch == 4'b0010) s.src1 = s.src1 & ~64'd3;
            drive(s);
            exp_q.push_back(model(s));
            step();
            e = exp_q.pop_front();
            n_cmp++; if (ex_if.result !== e.result) begin n_err++; $display("FAIL b2b%0d_result: ctl=%b got %h want %h", i, s.alu_ctr, ex_if.result, e.result); end
            n_cmp++; if (ex_if.nxtpc !== e.nxtpc) begin n_err++; $display("FAIL b2b%0d_nxtpc: br=%b got %h want %h", i, s.branch, ex_if.nxtpc, e.nxtpc); end
            n_cmp++; if (ex_if.is_jmp !== e.is_jmp) begin n_err++; $display("FAIL b2b%0d_is_jmp: br=%b got %b want %b", i, s.branch, ex_if.is_jmp, e.is_jmp); end
        end
    endtask

    initial begin
        test_reset();
        test_addw();
        test_branch();
        test_jump();
        test_stall();
        test_ecall();
        test_csr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
